// File: rtl/snoop_pkg.sv
// Shared state type, report geometry and arithmetic helpers for multi_channel_snooper.
// Defining SNOOP_MINMAX_EN widens the per-channel report block with min/max packet size words.
package snoop_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

`ifdef SNOOP_MINMAX_EN
    localparam int WORDS_PER_CH = 5;
`else
    localparam int WORDS_PER_CH = 3;
`endif

    // Widest keep vector handled by popcount.
    localparam int KEEP_MAX = 128;

    function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // a + b clamped to the all-ones value of a counter that is width bits wide.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [64:0] sum;
        logic [64:0] lim;
        lim = (65'd1 << width) - 65'd1;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/snoop_channel.sv
// Per-channel flit/packet/byte counters, in-flight packet accumulator and packet size output.
// With SNOOP_MINMAX_EN the channel also tracks the smallest and largest completed packet.
module snoop_channel
    import snoop_pkg::*;
#(
    parameter int TKEEP_WIDTH = 64,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   clear,
    input  logic                   beat,
    input  logic                   last,
    input  logic [TKEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]   flits,
    output logic [CNT_WIDTH-1:0]   pkts,
    output logic [CNT_WIDTH-1:0]   byte_cnt,
`ifdef SNOOP_MINMAX_EN
    output logic [CNT_WIDTH-1:0]   min_size,
    output logic [CNT_WIDTH-1:0]   max_size,
`endif
    output logic [CNT_WIDTH-1:0]   pkt_size,
    output logic                   pkt_size_valid
);

    logic [CNT_WIDTH-1:0] acc;
    logic [63:0]          pc64;
    logic [CNT_WIDTH-1:0] size_now;

    assign pc64     = 64'(popcount(KEEP_MAX'(keep)));
    assign size_now = CNT_WIDTH'(sat_add(64'(acc), pc64, CNT_WIDTH));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            flits          <= '0;
            pkts           <= '0;
            byte_cnt       <= '0;
            acc            <= '0;
            pkt_size       <= '0;
            pkt_size_valid <= 1'b0;
        end else begin
            pkt_size_valid <= 1'b0;
            if (clear) begin
                flits    <= '0;
                pkts     <= '0;
                byte_cnt <= '0;
                acc      <= '0;
            end else if (beat) begin
                flits    <= CNT_WIDTH'(sat_add(64'(flits), 64'd1, CNT_WIDTH));
                byte_cnt <= CNT_WIDTH'(sat_add(64'(byte_cnt), pc64, CNT_WIDTH));
                if (last) begin
                    pkts           <= CNT_WIDTH'(sat_add(64'(pkts), 64'd1, CNT_WIDTH));
                    pkt_size       <= size_now;
                    pkt_size_valid <= 1'b1;
                    acc            <= '0;
                end else begin
                    acc <= size_now;
                end
            end
        end
    end

`ifdef SNOOP_MINMAX_EN
    logic [CNT_WIDTH-1:0] min_r;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            min_r    <= '0;
            max_size <= '0;
        end else if (clear) begin
            min_r    <= '1;
            max_size <= '0;
        end else if (beat && last) begin
            if (size_now < min_r) min_r <= size_now;
            if (size_now > max_size) max_size <= size_now;
        end
    end

    // The all-ones seed would be meaningless to software, so a packetless channel reports 0.
    assign min_size = (pkts == '0) ? '0 : min_r;
`endif

endmodule

// File: rtl/multi_channel_snooper.sv
// Passive N-channel AXI-stream monitor: windowed counting, then a serialised 64-bit report.
// Build option SNOOP_MINMAX_EN adds per-channel min/max packet size to the report.
module multi_channel_snooper
    import snoop_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic [NUM_CH*TKEEP_WIDTH-1:0] mon_TKEEP,
    input  logic [NUM_CH-1:0]             mon_TVALID,
    input  logic [NUM_CH-1:0]             mon_TREADY,
    input  logic [NUM_CH-1:0]             mon_TLAST,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic                          measure,
    output logic [63:0]                   report_TDATA,
    output logic [7:0]                    report_TKEEP,
    output logic                          report_TVALID,
    input  logic                          report_TREADY,
    output logic                          report_TLAST,
    output logic                          busy,
    output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_size,
    output logic [NUM_CH-1:0]             pkt_size_valid,
    output logic                          measure_sync_out
);

    localparam int NUM_WORDS = 1 + WORDS_PER_CH * NUM_CH;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    state_t               state, state_nx;
    logic                 clear;
    logic                 accept;
    logic [NUM_CH-1:0]    beat;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     nxt_idx;
    logic [63:0]          words [NUM_WORDS];

    logic [CNT_WIDTH-1:0] flits    [NUM_CH];
    logic [CNT_WIDTH-1:0] pkts     [NUM_CH];
    logic [CNT_WIDTH-1:0] byte_cnt [NUM_CH];
`ifdef SNOOP_MINMAX_EN
    logic [CNT_WIDTH-1:0] min_size [NUM_CH];
    logic [CNT_WIDTH-1:0] max_size [NUM_CH];
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (measure) state_nx = MEASURE;
            MEASURE: if (!measure) state_nx = REPORT;
            REPORT:  if (accept && report_TLAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign clear   = (state == IDLE) && measure;
    assign accept  = report_TVALID && report_TREADY;
    assign busy    = (state != IDLE);
    assign beat    = {NUM_CH{state == MEASURE}} & mon_TVALID & mon_TREADY & ch_enable;
    assign nxt_idx = idx + IDX_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        snoop_channel #(
            .TKEEP_WIDTH(TKEEP_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_ch (
            .clk           (clk),
            .areset        (areset),
            .clear         (clear),
            .beat          (beat[c]),
            .last          (mon_TLAST[c]),
            .keep          (mon_TKEEP[c*TKEEP_WIDTH +: TKEEP_WIDTH]),
            .flits         (flits[c]),
            .pkts          (pkts[c]),
            .byte_cnt      (byte_cnt[c]),
`ifdef SNOOP_MINMAX_EN
            .min_size      (min_size[c]),
            .max_size      (max_size[c]),
`endif
            .pkt_size      (pkt_size[c*CNT_WIDTH +: CNT_WIDTH]),
            .pkt_size_valid(pkt_size_valid[c])
        );
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)                 cycle_cnt <= '0;
        else if (clear)             cycle_cnt <= '0;
        else if (state == MEASURE)  cycle_cnt <= CNT_WIDTH'(sat_add(64'(cycle_cnt), 64'd1, CNT_WIDTH));
    end

    always_comb begin
        words[0] = 64'(cycle_cnt);
        for (int c = 0; c < NUM_CH; c++) begin
            words[1 + c*WORDS_PER_CH]     = 64'(flits[c]);
            words[1 + c*WORDS_PER_CH + 1] = 64'(pkts[c]);
            words[1 + c*WORDS_PER_CH + 2] = 64'(byte_cnt[c]);
`ifdef SNOOP_MINMAX_EN
            words[1 + c*WORDS_PER_CH + 3] = 64'(min_size[c]);
            words[1 + c*WORDS_PER_CH + 4] = 64'(max_size[c]);
`endif
        end
    end

    // Word 0 is loaded one cycle into REPORT so the beat on the closing cycle is already counted.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            idx           <= '0;
            report_TDATA  <= '0;
            report_TKEEP  <= '0;
            report_TVALID <= 1'b0;
            report_TLAST  <= 1'b0;
        end else if (state == REPORT) begin
            if (!report_TVALID) begin
                idx           <= '0;
                report_TDATA  <= words[0];
                report_TKEEP  <= 8'hFF;
                report_TVALID <= 1'b1;
                report_TLAST  <= 1'b0;
            end else if (report_TREADY) begin
                if (report_TLAST) begin
                    report_TDATA  <= '0;
                    report_TKEEP  <= '0;
                    report_TVALID <= 1'b0;
                    report_TLAST  <= 1'b0;
                end else begin
                    idx          <= nxt_idx;
                    report_TDATA <= words[nxt_idx];
                    report_TLAST <= (nxt_idx == IDX_W'(NUM_WORDS - 1));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) measure_sync_out <= 1'b0;
        else        measure_sync_out <= measure;
    end

endmodule

// File: tb/tb_multi_channel_snooper.sv
// Self-checking bench for multi_channel_snooper: vector table, report/pkt_size scoreboards,
// hand sequences for stalls, mid-report reset and counter saturation.
module tb_multi_channel_snooper;

    localparam int NUM_CH = 4;
    localparam int KW     = 64;
    localparam int CW     = 64;
`ifdef SNOOP_MINMAX_EN
    localparam int W         = 5;
    localparam int EXP_WORDS = 21;
`else
    localparam int W         = 3;
    localparam int EXP_WORDS = 13;
`endif

    logic                   clk = 1'b0;
    logic                   areset;
    logic [NUM_CH*KW-1:0]   mon_TKEEP;
    logic [NUM_CH-1:0]      mon_TVALID, mon_TREADY, mon_TLAST, ch_enable;
    logic                   measure;
    logic [63:0]            report_TDATA;
    logic [7:0]             report_TKEEP;
    logic                   report_TVALID, report_TREADY, report_TLAST, busy;
    logic [NUM_CH*CW-1:0]   pkt_size;
    logic [NUM_CH-1:0]      pkt_size_valid;
    logic                   measure_sync_out;

    logic [7:0]  s_keep;
    logic        s_valid, s_ready, s_last, s_en, s_measure;
    logic [63:0] s_TDATA;
    logic [7:0]  s_TKEEP;
    logic        s_TVALID, s_TLAST, s_busy, s_psv, s_msync;
    logic [3:0]  s_psize;
    logic        s_TREADY = 1'b1;

    always #5 clk = ~clk;

    multi_channel_snooper #(.NUM_CH(NUM_CH), .TDATA_WIDTH(512), .TKEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .areset(areset), .mon_TKEEP(mon_TKEEP), .mon_TVALID(mon_TVALID),
        .mon_TREADY(mon_TREADY), .mon_TLAST(mon_TLAST), .ch_enable(ch_enable), .measure(measure),
        .report_TDATA(report_TDATA), .report_TKEEP(report_TKEEP), .report_TVALID(report_TVALID),
        .report_TREADY(report_TREADY), .report_TLAST(report_TLAST), .busy(busy),
        .pkt_size(pkt_size), .pkt_size_valid(pkt_size_valid), .measure_sync_out(measure_sync_out));

    // 4-bit counters on a single channel, small enough to drive into saturation.
    multi_channel_snooper #(.NUM_CH(1), .TDATA_WIDTH(64), .TKEEP_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .areset(areset), .mon_TKEEP(s_keep), .mon_TVALID(s_valid),
        .mon_TREADY(s_ready), .mon_TLAST(s_last), .ch_enable(s_en), .measure(s_measure),
        .report_TDATA(s_TDATA), .report_TKEEP(s_TKEEP), .report_TVALID(s_TVALID),
        .report_TREADY(s_TREADY), .report_TLAST(s_TLAST), .busy(s_busy),
        .pkt_size(s_psize), .pkt_size_valid(s_psv), .measure_sync_out(s_msync));

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model state: 0 idle, 1 measuring, 2 reporting.
    int          mst = 0;
    logic [63:0] m_cyc;
    logic [63:0] m_flit [NUM_CH];
    logic [63:0] m_pkt  [NUM_CH];
    logic [63:0] m_byte [NUM_CH];
    logic [63:0] m_acc  [NUM_CH];
    logic [63:0] m_min  [NUM_CH];
    logic [63:0] m_max  [NUM_CH];
    logic [64:0] exp_q [$];
    logic [63:0] exp_size_q [NUM_CH][$];
    logic [63:0] rx_words [64];
    int          rx_n = 0;
    logic        rdy_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        report_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_report();
        logic [64:0] t;
        exp_q.push_back({1'b0, m_cyc});
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q.push_back({1'b0, m_flit[c]});
            exp_q.push_back({1'b0, m_pkt[c]});
            exp_q.push_back({1'b0, m_byte[c]});
`ifdef SNOOP_MINMAX_EN
            exp_q.push_back({1'b0, (m_pkt[c] == 64'd0) ? 64'd0 : m_min[c]});
            exp_q.push_back({1'b0, m_max[c]});
`endif
        end
        t = exp_q.pop_back();
        t[64] = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic step(input logic meas, input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                        input logic [NUM_CH-1:0] l, input logic [NUM_CH-1:0] en,
                        input logic [NUM_CH*KW-1:0] k, input logic push_model);
        logic [63:0] pcnt;
        logic [63:0] sz;
        measure = meas; mon_TVALID = v; mon_TREADY = r; mon_TLAST = l; ch_enable = en; mon_TKEEP = k;
        if (mst == 1) begin
            m_cyc++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (v[c] && r[c] && en[c]) begin
                    pcnt = 64'($countones(k[c*KW +: KW]));
                    m_flit[c]++;
                    m_byte[c] += pcnt;
                    if (l[c]) begin
                        sz = m_acc[c] + pcnt;
                        m_pkt[c]++;
                        if (push_model) exp_size_q[c].push_back(sz);
                        if (sz < m_min[c]) m_min[c] = sz;
                        if (sz > m_max[c]) m_max[c] = sz;
                        m_acc[c] = 64'd0;
                    end else begin
                        m_acc[c] += pcnt;
                    end
                end
            end
            if (!meas) begin
                mst = 2;
                push_report();
            end
        end else if (mst == 0 && meas) begin
            mst = 1;
            m_cyc = 64'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_flit[c] = 0; m_pkt[c] = 0; m_byte[c] = 0; m_acc[c] = 0;
                m_min[c] = '1; m_max[c] = 0;
            end
        end
        tick();
    endtask

    task automatic idle_step(input logic meas);
        step(meas, '0, '0, '0, '1, '0, 1'b0);
    endtask

    task automatic rand_step(input logic meas);
        logic [NUM_CH*KW-1:0] k;
        for (int c = 0; c < NUM_CH; c++)
            k[c*KW +: KW] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
        step(meas, NUM_CH'($urandom), NUM_CH'($urandom), NUM_CH'($urandom),
             NUM_CH'($urandom) | NUM_CH'($urandom), k, 1'b1);
    endtask

    task automatic wait_report(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || report_TVALID || busy) && n < budget) begin
            idle_step(1'b0);
            n++;
        end
        if (n >= budget) begin
            vectors++;
            errors++;
            $display("FAIL report_timeout: %0d words still outstanding after %0d cycles, required 0",
                     exp_q.size(), n);
            exp_q.delete();
        end
        mst = 0;
        rdy_rand = 1'b0;
        for (int c = 0; c < NUM_CH; c++) check("pkt_size_pending", 64'(exp_size_q[c].size()), 64'd0);
    endtask

    // Output monitor: report scoreboard, stall stability and packet size scoreboard.
    logic        pv = 1'b0, pr = 1'b0, plast = 1'b0;
    logic [63:0] pdata = '0;

    always @(negedge clk) begin
        if (areset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid_held", 64'(report_TVALID), 64'd1);
                check("stall_data_held", report_TDATA, pdata);
                check("stall_last_held", 64'(report_TLAST), 64'(plast));
            end
            if (report_TVALID && report_TREADY) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL report_extra: got word %0h, required no word", report_TDATA);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check("report_data", report_TDATA, e[63:0]);
                    check("report_last", 64'(report_TLAST), 64'(e[64]));
                    check("report_keep", 64'(report_TKEEP), 64'hFF);
                    if (rx_n < 64) rx_words[rx_n] = report_TDATA;
                    rx_n++;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (pkt_size_valid[c]) begin
                    if (exp_size_q[c].size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL pkt_size_extra ch%0d: got %0d, required no pulse", c, pkt_size[c*CW +: CW]);
                    end else begin
                        check("pkt_size", pkt_size[c*CW +: CW], exp_size_q[c].pop_front());
                    end
                end
            end
            pv = report_TVALID; pr = report_TREADY; pdata = report_TDATA; plast = report_TLAST;
        end
    end

    typedef struct {
        int          ch;
        logic        v, r, en, l;
        logic [63:0] keep;
        logic        exp_pkt;
        logic [63:0] exp_size;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0]    v, r, l, en;
        logic [NUM_CH*KW-1:0] k;
        logic [63:0]          s_rx [8];
        logic                 s_lst [8];
        int                   sn, n;

        tbl[0]  = '{0, 1, 1, 1, 0, '1, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 1, '1, 1, 128};
        tbl[2]  = '{0, 1, 1, 1, 0, '1, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 1, '1, 1, 128};
        tbl[4]  = '{0, 1, 1, 1, 0, '1, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 1, '1, 1, 128};
        tbl[6]  = '{1, 1, 1, 1, 0, '1, 0, 0};
        tbl[7]  = '{1, 1, 0, 1, 1, 64'hF, 0, 0};
        tbl[8]  = '{1, 1, 1, 1, 1, 64'hF, 1, 68};
        tbl[9]  = '{1, 1, 1, 0, 1, '1, 0, 0};
        tbl[10] = '{2, 1, 1, 1, 1, 64'h8000_0000_0000_0001, 1, 2};
        tbl[11] = '{2, 1, 1, 1, 0, 64'hF0F0, 0, 0};
        tbl[12] = '{2, 1, 1, 1, 0, 64'h0, 0, 0};
        tbl[13] = '{2, 1, 1, 1, 1, 64'h1, 1, 9};
        tbl[14] = '{3, 0, 1, 1, 1, '1, 0, 0};
        tbl[15] = '{3, 1, 1, 1, 1, 64'hFF00_0000_0000_0000, 1, 8};
        tbl[16] = '{3, 1, 1, 1, 0, '1, 0, 0};

        areset = 1'b1; measure = 1'b1;
        mon_TKEEP = '0; mon_TVALID = '0; mon_TREADY = '0; mon_TLAST = '0; ch_enable = '0;
        s_keep = '0; s_valid = 0; s_ready = 0; s_last = 0; s_en = 0; s_measure = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(report_TVALID), 64'd0);
        check("rst_tdata", report_TDATA, 64'd0);
        check("rst_tlast", 64'(report_TLAST), 64'd0);
        check("rst_tkeep", 64'(report_TKEEP), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_size", 64'(pkt_size[CW-1:0]) | 64'(pkt_size[4*CW-1:3*CW]), 64'd0);
        check("rst_pkt_valid", 64'(pkt_size_valid), 64'd0);
        check("rst_measure_sync", 64'(measure_sync_out), 64'd0);
        measure = 1'b0;
        areset = 1'b0;
        tick();

        // Window 1: table vectors, last row applied on the closing cycle.
        rx_n = 0;
        idle_step(1'b1);
        for (int i = 0; i < 17; i++) begin
            v = '0; r = '0; l = '0; en = '1; k = '0;
            v[tbl[i].ch] = tbl[i].v; r[tbl[i].ch] = tbl[i].r; l[tbl[i].ch] = tbl[i].l;
            en[tbl[i].ch] = tbl[i].en; k[tbl[i].ch*KW +: KW] = tbl[i].keep;
            if (tbl[i].exp_pkt) exp_size_q[tbl[i].ch].push_back(tbl[i].exp_size);
            step((i != 16), v, r, l, en, k, 1'b0);
        end
        wait_report(500);
        check("w1_words", 64'(rx_n), 64'(EXP_WORDS));
        check("w1_cycles", rx_words[0], 64'd17);
        check("w1_ch0_flits", rx_words[1], 64'd6);
        check("w1_ch0_pkts", rx_words[2], 64'd3);
        check("w1_ch0_bytes", rx_words[3], 64'd384);
        check("w1_ch1_flits", rx_words[1+W], 64'd2);
        check("w1_ch1_bytes", rx_words[3+W], 64'd68);
        check("w1_ch2_bytes", rx_words[3+2*W], 64'd11);
        check("w1_ch3_flits", rx_words[1+3*W], 64'd2);
        check("w1_ch3_pkts", rx_words[2+3*W], 64'd1);
        check("w1_ch3_bytes", rx_words[3+3*W], 64'd72);

        // Window 2: 100 cycles; ch3 packet proves the open partial from window 1 was dropped.
        rx_n = 0;
        idle_step(1'b1);
        check("msync_rise", 64'(measure_sync_out), 64'd1);
        check("busy_measure", 64'(busy), 64'd1);
        for (int i = 0; i < 99; i++) begin
            if (i == 10) begin
                exp_size_q[3].push_back(64'd1);
                step(1'b1, 4'b1000, 4'b1000, 4'b1000, '1, {64'h1, 192'd0}, 1'b0);
            end else begin
                idle_step(1'b1);
            end
        end
        idle_step(1'b0);
        check("msync_fall", 64'(measure_sync_out), 64'd0);
        wait_report(500);
        check("w2_words", 64'(rx_n), 64'(EXP_WORDS));
        check("w2_cycles", rx_words[0], 64'd100);
        check("w2_ch3_pkts", rx_words[2+3*W], 64'd1);

        // Window 3: random traffic with random report back-pressure.
        rx_n = 0;
        idle_step(1'b1);
        for (int i = 0; i < 60; i++) rand_step(1'b1);
        rand_step(1'b0);
        rdy_rand = 1'b1;
        wait_report(1000);

        // Window 4: reset while word 5 is presented.
        rx_n = 0;
        idle_step(1'b1);
        for (int i = 0; i < 30; i++) rand_step(1'b1);
        idle_step(1'b0);
        n = 0;
        while (rx_n < 5 && n < 200) begin
            idle_step(1'b0);
            n++;
        end
        check("w4_reached_word5", 64'(rx_n), 64'd5);
        areset = 1'b1;
        #1;
        check("abort_tvalid", 64'(report_TVALID), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_tlast", 64'(report_TLAST), 64'd0);
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) exp_size_q[c].delete();
        mst = 0;
        tick();
        areset = 1'b0;
        tick();
        check("post_abort_tvalid", 64'(report_TVALID), 64'd0);

        // Window 5: fresh counts after the abort.
        rx_n = 0;
        idle_step(1'b1);
        step(1'b1, 4'b0001, 4'b0001, 4'b0000, '1, {192'd0, {64{1'b1}}}, 1'b1);
        step(1'b1, 4'b0001, 4'b0001, 4'b0000, '1, {192'd0, {64{1'b1}}}, 1'b1);
        step(1'b1, 4'b0001, 4'b0001, 4'b0001, '1, {192'd0, {64{1'b1}}}, 1'b1);
        idle_step(1'b0);
        wait_report(500);
        check("w5_cycles", rx_words[0], 64'd4);
        check("w5_ch0_flits", rx_words[1], 64'd3);
        check("w5_ch0_bytes", rx_words[3], 64'd192);
        check("w5_ch1_flits", rx_words[1+W], 64'd0);

`ifdef SNOOP_MINMAX_EN
        // Window 6: ch2 packets of 64, 256 and 4 bytes; ch3 silent.
        rx_n = 0;
        idle_step(1'b1);
        step(1'b1, 4'b0100, 4'b0100, 4'b0100, '1, {64'd0, {64{1'b1}}, 128'd0}, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'b0100, 4'b0100, (i == 3) ? 4'b0100 : 4'b0000, '1, {64'd0, {64{1'b1}}, 128'd0}, 1'b1);
        step(1'b1, 4'b0100, 4'b0100, 4'b0100, '1, {64'd0, 64'hF, 128'd0}, 1'b1);
        idle_step(1'b0);
        wait_report(500);
        check("w6_ch2_min", rx_words[4+2*W], 64'd4);
        check("w6_ch2_max", rx_words[5+2*W], 64'd256);
        check("w6_ch3_min", rx_words[4+3*W], 64'd0);
        check("w6_ch3_max", rx_words[5+3*W], 64'd0);
`endif

        // Saturation on the 4-bit instance: 21 cycles, 20 single-beat 8-byte packets.
        s_measure = 1'b1;
        tick();
        s_valid = 1; s_ready = 1; s_last = 1; s_en = 1; s_keep = 8'hFF;
        repeat (20) tick();
        s_valid = 0; s_measure = 0;
        tick();
        sn = 0; n = 0;
        while (sn < 1 + W && n < 50) begin
            if (s_TVALID) begin
                s_rx[sn] = s_TDATA;
                s_lst[sn] = s_TLAST;
                sn++;
            end
            tick();
            n++;
        end
        check("sat_words", 64'(sn), 64'(1 + W));
        check("sat_cycles", s_rx[0], 64'd15);
        check("sat_flits", s_rx[1], 64'd15);
        check("sat_pkts", s_rx[2], 64'd15);
        check("sat_bytes", s_rx[3], 64'd15);
        check("sat_last", 64'(s_lst[W]), 64'd1);
        check("sat_pkt_size", 64'(s_psize), 64'd8);
`ifdef SNOOP_MINMAX_EN
        check("sat_min", s_rx[4], 64'd8);
        check("sat_max", s_rx[5], 64'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
